// File: rtl/noc_local_ni.sv
// noc_local_ni: network interface between a processing element and the local
// port of a NOC router.
// - TX path: host requests are packed into {payload, dest_x, dest_y} flits,
//   queued, and injected under credit-based flow control.
// - RX path: flits ejected by the router are queued, and one credit is
//   returned for every flit the host consumes.
// - Optional build macro NOC_NI_STATS_EN adds tx_flits_o / rx_flits_o
//   traffic counters.
module noc_local_ni #(
    parameter int XCOORD   = 0,
    parameter int YCOORD   = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CREDITS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_payload_i,
    input  logic [3:0]  tx_dest_x_i,
    input  logic [3:0]  tx_dest_y_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [15:0] net_data_o,
    output logic        net_enable_o,
    input  logic        net_credit_i,
    input  logic [15:0] net_data_i,
    input  logic        net_enable_i,
    output logic        net_credit_o,
    output logic [15:0] rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_pop_i,
    output logic        rx_overflow_o
`ifdef NOC_NI_STATS_EN
    ,
    output logic [15:0] tx_flits_o,
    output logic [15:0] rx_flits_o
`endif
);

    localparam int TAW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int TCW = $clog2(TX_DEPTH + 1);
    localparam int RAW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int RCW = $clog2(RX_DEPTH + 1);
    localparam int CW  = $clog2(CREDITS + 1);

    localparam logic [TCW-1:0] TX_FULL    = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_FULL    = RCW'(RX_DEPTH);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(CREDITS);
    localparam logic [TAW-1:0] TX_LAST    = TAW'(TX_DEPTH - 1);
    localparam logic [RAW-1:0] RX_LAST    = RAW'(RX_DEPTH - 1);

    // Configuration sanity: the router coordinates only have 4 bits, and the
    // FIFOs need at least two entries. Self-addressed flits need no special
    // handling here because the router loops them back to the local port.
    if (TX_DEPTH < 32'sd2 || (TX_DEPTH & (TX_DEPTH - 32'sd1)) != 32'sd0) begin : g_chk_tx_depth
        $error("noc_local_ni: TX_DEPTH must be a power of 2 and at least 2");
    end
    if (RX_DEPTH < 32'sd2 || CREDITS < 32'sd1) begin : g_chk_rx_credit
        $error("noc_local_ni: RX_DEPTH must be at least 2 and CREDITS at least 1");
    end
    if (XCOORD < 32'sd0 || XCOORD > 32'sd15 || YCOORD < 32'sd0 || YCOORD > 32'sd15) begin : g_chk_coord
        $error("noc_local_ni: XCOORD/YCOORD must fit in 4 bits");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    function automatic logic [TAW-1:0] tx_ptr_next(input logic [TAW-1:0] ptr);
        if (ptr == TX_LAST) begin
            return {TAW{1'b0}};
        end else begin
            return ptr + TAW'(1'b1);
        end
    endfunction

    function automatic logic [RAW-1:0] rx_ptr_next(input logic [RAW-1:0] ptr);
        if (ptr == RX_LAST) begin
            return {RAW{1'b0}};
        end else begin
            return ptr + RAW'(1'b1);
        end
    endfunction

    // TX side state
    logic [15:0]    tx_mem_r [TX_DEPTH];
    logic [TAW-1:0] tx_wr_ptr_r;
    logic [TAW-1:0] tx_rd_ptr_r;
    logic [TCW-1:0] tx_count_r;
    logic [CW-1:0]  credit_r;
    tx_state_t      state_r;
    tx_state_t      state_next_s;
    logic           send_s;
    logic           tx_push_s;
    logic           tx_can_send_s;
    logic [15:0]    net_data_r;
    logic           net_enable_r;

    // RX side state
    logic [15:0]    rx_mem_r [RX_DEPTH];
    logic [RAW-1:0] rx_wr_ptr_r;
    logic [RAW-1:0] rx_rd_ptr_r;
    logic [RCW-1:0] rx_count_r;
    logic           rx_full_s;
    logic           rx_pop_s;
    logic           rx_push_s;
    logic           rx_drop_s;
    logic           net_credit_r;
    logic           rx_overflow_r;

    // Ready reflects only the registered count, so a same-cycle pop never
    // frees a slot early; it is held low while reset is asserted.
    assign tx_ready_o    = ~rst & (tx_count_r != TX_FULL);
    assign tx_push_s     = tx_valid_i & tx_ready_o;
    assign tx_can_send_s = (tx_count_r != {TCW{1'b0}}) & (credit_r != {CW{1'b0}});

    assign net_data_o    = net_data_r;
    assign net_enable_o  = net_enable_r;

    // Send FSM: a flit leaves whenever one is queued and a credit is held.
    always_comb begin
        state_next_s = state_r;
        send_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (tx_can_send_s) begin
                    state_next_s = SEND;
                    send_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                    send_s       = 1'b0;
                end
            end
            SEND: begin
                if (tx_can_send_s) begin
                    state_next_s = SEND;
                    send_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                    send_s       = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
                send_s       = 1'b0;
            end
        endcase
    end

    // Send FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // TX FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= {tx_payload_i, tx_dest_x_i, tx_dest_y_i};
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr_r <= {TAW{1'b0}};
            tx_rd_ptr_r <= {TAW{1'b0}};
            tx_count_r  <= {TCW{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_ptr_next(tx_wr_ptr_r);
            end
            if (send_s) begin
                tx_rd_ptr_r <= tx_ptr_next(tx_rd_ptr_r);
            end
            case ({tx_push_s, send_s})
                2'b10:   tx_count_r <= tx_count_r + TCW'(1'b1);
                2'b01:   tx_count_r <= tx_count_r - TCW'(1'b1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // Credit counter: a send consumes one, a returned credit adds one
    // (clamped at the router buffer depth); both together cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_r <= CREDIT_MAX;
        end else begin
            case ({send_s, net_credit_i})
                2'b10:   credit_r <= credit_r - CW'(1'b1);
                2'b01:   credit_r <= (credit_r == CREDIT_MAX) ? CREDIT_MAX : credit_r + CW'(1'b1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Registered flit output toward the router; data is zero between flits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            net_data_r   <= 16'h0000;
            net_enable_r <= 1'b0;
        end else begin
            net_enable_r <= send_s;
            net_data_r   <= send_s ? tx_mem_r[tx_rd_ptr_r] : 16'h0000;
        end
    end

    // RX handshake: a write to a full FIFO is only accepted when the head
    // is consumed in the same cycle, otherwise the flit is dropped.
    assign rx_full_s  = (rx_count_r == RX_FULL);
    assign rx_valid_o = (rx_count_r != {RCW{1'b0}});
    assign rx_pop_s   = rx_pop_i & rx_valid_o;
    assign rx_push_s  = net_enable_i & (~rx_full_s | rx_pop_s);
    assign rx_drop_s  = net_enable_i & rx_full_s & ~rx_pop_s;
    assign rx_data_o  = rx_valid_o ? rx_mem_r[rx_rd_ptr_r] : 16'h0000;

    assign net_credit_o  = net_credit_r;
    assign rx_overflow_o = rx_overflow_r;

    // RX FIFO storage; on full write+pop the slot being freed is reused.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= net_data_i;
        end
    end

    // RX FIFO pointers, occupancy, credit return and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr_r   <= {RAW{1'b0}};
            rx_rd_ptr_r   <= {RAW{1'b0}};
            rx_count_r    <= {RCW{1'b0}};
            net_credit_r  <= 1'b0;
            rx_overflow_r <= 1'b0;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_ptr_next(rx_wr_ptr_r);
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_ptr_next(rx_rd_ptr_r);
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RCW'(1'b1);
                2'b01:   rx_count_r <= rx_count_r - RCW'(1'b1);
                default: rx_count_r <= rx_count_r;
            endcase
            net_credit_r  <= rx_pop_s;
            rx_overflow_r <= rx_overflow_r | rx_drop_s;
        end
    end

`ifdef NOC_NI_STATS_EN
    logic [15:0] tx_flits_r;
    logic [15:0] rx_flits_r;

    assign tx_flits_o = tx_flits_r;
    assign rx_flits_o = rx_flits_r;

    // Free-running traffic counters, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_flits_r <= 16'h0000;
            rx_flits_r <= 16'h0000;
        end else begin
            tx_flits_r <= send_s ? tx_flits_r + 16'h0001 : tx_flits_r;
            rx_flits_r <= rx_push_s ? rx_flits_r + 16'h0001 : rx_flits_r;
        end
    end
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Self-checking bench for noc_local_ni. A queue-based reference model of the
// TX FIFO, credit pool and RX FIFO predicts every output one clock at a time.
`timescale 1ns/1ps
module tb_noc_local_ni;

    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;
    localparam int CREDITS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_payload_i;
    logic [3:0]  tx_dest_x_i;
    logic [3:0]  tx_dest_y_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [15:0] net_data_o;
    logic        net_enable_o;
    logic        net_credit_i;
    logic [15:0] net_data_i;
    logic        net_enable_i;
    logic        net_credit_o;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_pop_i;
    logic        rx_overflow_o;
`ifdef NOC_NI_STATS_EN
    logic [15:0] tx_flits_o;
    logic [15:0] rx_flits_o;
`endif

    always #5 clk = ~clk;

    noc_local_ni #(
        .XCOORD(2), .YCOORD(3), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_payload_i(tx_payload_i), .tx_dest_x_i(tx_dest_x_i), .tx_dest_y_i(tx_dest_y_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .net_data_o(net_data_o), .net_enable_o(net_enable_o), .net_credit_i(net_credit_i),
        .net_data_i(net_data_i), .net_enable_i(net_enable_i), .net_credit_o(net_credit_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_pop_i(rx_pop_i),
        .rx_overflow_o(rx_overflow_o)
`ifdef NOC_NI_STATS_EN
        , .tx_flits_o(tx_flits_o), .rx_flits_o(rx_flits_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [15:0] m_tx_q[$];
    logic [15:0] m_rx_q[$];
    int          m_credit;
    bit          m_ovf;
    bit          m_net_en;
    logic [15:0] m_net_data;
    bit          m_net_cr;
    int          m_tx_cnt;
    int          m_rx_cnt;

    task automatic model_reset();
        m_tx_q.delete();
        m_rx_q.delete();
        m_credit   = CREDITS;
        m_ovf      = 1'b0;
        m_net_en   = 1'b0;
        m_net_data = 16'h0000;
        m_net_cr   = 1'b0;
        m_tx_cnt   = 0;
        m_rx_cnt   = 0;
    endtask

    task automatic clear_inputs();
        tx_payload_i = 8'h00; tx_dest_x_i = 4'h0; tx_dest_y_i = 4'h0; tx_valid_i = 1'b0;
        net_credit_i = 1'b0;  net_data_i = 16'h0000; net_enable_i = 1'b0; rx_pop_i = 1'b0;
    endtask

    // One clock edge for both DUT and model; returns #1 after the edge.
    task automatic cycle();
        bit push, send, pop, wr, cr, en_in;
        logic [15:0] flit, din;
        push  = tx_valid_i && (m_tx_q.size() < TX_DEPTH);
        send  = (m_tx_q.size() > 0) && (m_credit > 0);
        pop   = rx_pop_i && (m_rx_q.size() > 0);
        en_in = net_enable_i;
        wr    = en_in && ((m_rx_q.size() < RX_DEPTH) || pop);
        cr    = net_credit_i;
        flit  = {tx_payload_i, tx_dest_x_i, tx_dest_y_i};
        din   = net_data_i;
        @(posedge clk);
        #1;
        m_net_en = send;
        if (send) begin m_net_data = m_tx_q.pop_front(); m_tx_cnt++; end
        if (push) m_tx_q.push_back(flit);
        if (send && !cr) m_credit--;
        else if (!send && cr && m_credit < CREDITS) m_credit++;
        if (pop) void'(m_rx_q.pop_front());
        if (wr) begin m_rx_q.push_back(din); m_rx_cnt++; end
        if (en_in && !wr) m_ovf = 1'b1;
        m_net_cr = pop;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        checks++;
        if ({tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o} !== 5'b0 ||
            net_data_o !== 16'h0 || rx_data_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_in: ctl=%b data=%h rx=%h expected all zero",
                     {tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o}, net_data_o, rx_data_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_release: ctl=%b expected 10000",
                     {tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o});
        end
    endtask

    task automatic test_tx_latency();
        tx_payload_i = 8'hA5; tx_dest_x_i = 4'd2; tx_dest_y_i = 4'd3; tx_valid_i = 1'b1;
        cycle();
        tx_valid_i = 1'b0;
        checks++;
        if (net_enable_o !== 1'b0) begin
            errors++; $display("FAIL tx_early: net_enable_o=%b expected 0", net_enable_o);
        end
        cycle();
        checks++;
        if (net_enable_o !== 1'b1 || net_data_o !== 16'hA523 || net_data_o !== m_net_data) begin
            errors++; $display("FAIL tx_first: en=%b data=%h expected en=1 data=a523", net_enable_o, net_data_o);
        end
        cycle();
        checks++;
        if (net_enable_o !== 1'b0) begin
            errors++; $display("FAIL tx_pulse: net_enable_o=%b expected 0", net_enable_o);
        end
    endtask

    task automatic test_credit_stall();
        int pushed, sent;
        do_reset();
        pushed = 0; sent = 0;
        for (int i = 0; i < 12; i++) begin
            tx_valid_i = (pushed < 8);
            if (tx_valid_i && m_tx_q.size() < TX_DEPTH) pushed++;
            {tx_payload_i, tx_dest_x_i, tx_dest_y_i} = 16'($urandom);
            cycle();
            if (net_enable_o) sent++;
            checks++;
            if (net_enable_o !== m_net_en || tx_ready_o !== (m_tx_q.size() < TX_DEPTH) ||
                (m_net_en && net_data_o !== m_net_data)) begin
                errors++;
                $display("FAIL stall_cyc%0d: en=%b rdy=%b data=%h expected en=%b rdy=%b data=%h", i,
                         net_enable_o, tx_ready_o, net_data_o, m_net_en, m_tx_q.size() < TX_DEPTH, m_net_data);
            end
        end
        tx_valid_i = 1'b0;
        checks++;
        if (sent != 4 || tx_ready_o !== 1'b0) begin
            errors++; $display("FAIL stall_count: sent=%0d ready=%b expected sent=4 ready=0", sent, tx_ready_o);
        end
        net_credit_i = 1'b1;
        cycle();
        net_credit_i = 1'b0;
        sent = 0;
        repeat (4) begin
            cycle();
            if (net_enable_o) sent++;
        end
        checks++;
        if (sent != 1 || tx_ready_o !== 1'b1) begin
            errors++; $display("FAIL stall_release: sent=%0d ready=%b expected sent=1 ready=1", sent, tx_ready_o);
        end
    endtask

    task automatic test_credit_clamp();
        int sent;
        do_reset();
        net_credit_i = 1'b1;
        repeat (5) cycle();
        net_credit_i = 1'b0;
        sent = 0;
        for (int i = 0; i < 14; i++) begin
            tx_valid_i = (i < 6);
            {tx_payload_i, tx_dest_x_i, tx_dest_y_i} = 16'($urandom);
            cycle();
            if (net_enable_o) sent++;
        end
        tx_valid_i = 1'b0;
        checks++;
        if (sent != 4) begin
            errors++; $display("FAIL credit_clamp: sent=%0d expected 4", sent);
        end
    endtask

    task automatic test_credit_coincident();
        int sent;
        do_reset();
        tx_valid_i = 1'b1;
        repeat (2) cycle();
        tx_valid_i = 1'b0;
        repeat (3) cycle();
        tx_valid_i = 1'b1;
        cycle();
        tx_valid_i = 1'b0;
        net_credit_i = 1'b1;
        cycle();
        net_credit_i = 1'b0;
        checks++;
        if (net_enable_o !== 1'b1) begin
            errors++; $display("FAIL coincide_send: net_enable_o=%b expected 1", net_enable_o);
        end
        sent = 0;
        for (int i = 0; i < 10; i++) begin
            tx_valid_i = (i < 4);
            {tx_payload_i, tx_dest_x_i, tx_dest_y_i} = 16'($urandom);
            cycle();
            if (net_enable_o) sent++;
        end
        tx_valid_i = 1'b0;
        checks++;
        if (sent != 2) begin
            errors++; $display("FAIL coincide_credit: sent=%0d expected 2", sent);
        end
    endtask

    task automatic test_rx_basic();
        do_reset();
        net_data_i = 16'h1234; net_enable_i = 1'b1;
        cycle();
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 16'h1234) begin
            errors++; $display("FAIL rx_first: valid=%b data=%h expected 1 1234", rx_valid_o, rx_data_o);
        end
        net_data_i = 16'h5678;
        cycle();
        net_enable_i = 1'b0;
        rx_pop_i = 1'b1;
        cycle();
        checks++;
        if (rx_data_o !== 16'h5678 || net_credit_o !== 1'b1) begin
            errors++; $display("FAIL rx_pop1: data=%h credit=%b expected 5678 1", rx_data_o, net_credit_o);
        end
        cycle();
        checks++;
        if (rx_valid_o !== 1'b0 || net_credit_o !== 1'b1) begin
            errors++; $display("FAIL rx_pop2: valid=%b credit=%b expected 0 1", rx_valid_o, net_credit_o);
        end
        cycle();
        rx_pop_i = 1'b0;
        checks++;
        if (net_credit_o !== 1'b0 || net_credit_o !== m_net_cr) begin
            errors++; $display("FAIL rx_pop_empty: credit=%b expected 0", net_credit_o);
        end
    endtask

    task automatic test_rx_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            net_data_i = 16'($urandom); net_enable_i = 1'b1;
            cycle();
            checks++;
            if (rx_overflow_o !== m_ovf || rx_overflow_o !== (i == 4)) begin
                errors++; $display("FAIL ovf_write%0d: overflow=%b expected %b", i, rx_overflow_o, m_ovf);
            end
        end
        net_enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_valid_o !== 1'b1 || rx_data_o !== m_rx_q[0]) begin
                errors++; $display("FAIL ovf_drain%0d: valid=%b data=%h expected 1 %h", i, rx_valid_o, rx_data_o, m_rx_q[0]);
            end
            rx_pop_i = 1'b1;
            cycle();
        end
        rx_pop_i = 1'b0;
        repeat (2) cycle();
        checks++;
        if (rx_overflow_o !== 1'b1 || rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky: overflow=%b valid=%b expected 1 0", rx_overflow_o, rx_valid_o);
        end
        do_reset();
        net_enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            net_data_i = 16'($urandom);
            cycle();
        end
        net_data_i = 16'hBEEF; rx_pop_i = 1'b1;
        cycle();
        net_enable_i = 1'b0; rx_pop_i = 1'b0;
        checks++;
        if (rx_overflow_o !== 1'b0 || net_credit_o !== 1'b1) begin
            errors++; $display("FAIL full_wr_pop: overflow=%b credit=%b expected 0 1", rx_overflow_o, net_credit_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_valid_o !== 1'b1 || rx_data_o !== m_rx_q[0] || (i == 3 && rx_data_o !== 16'hBEEF)) begin
                errors++; $display("FAIL full_drain%0d: valid=%b data=%h expected 1 %h", i, rx_valid_o, rx_data_o, m_rx_q[0]);
            end
            rx_pop_i = 1'b1;
            cycle();
        end
        rx_pop_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int sent;
        do_reset();
        tx_valid_i = 1'b1;
        repeat (4) cycle();
        tx_valid_i = 1'b0;
        repeat (2) cycle();
        tx_valid_i = 1'b1; net_enable_i = 1'b1; net_data_i = 16'hC0DE;
        repeat (3) cycle();
        tx_valid_i = 1'b0; net_enable_i = 1'b0;
        net_credit_i = 1'b1;
        repeat (2) cycle();
        net_credit_i = 1'b0;
        checks++;
        if (net_enable_o !== 1'b1 || rx_valid_o !== 1'b1) begin
            errors++; $display("FAIL mid_pre: en=%b rx_valid=%b expected 1 1", net_enable_o, rx_valid_o);
        end
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        checks++;
        if ({tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o} !== 5'b0 ||
            net_data_o !== 16'h0 || rx_data_o !== 16'h0) begin
            errors++; $display("FAIL mid_async: ctl=%b data=%h rx=%h expected zero",
                               {tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o}, net_data_o, rx_data_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sent = 0;
        repeat (6) begin
            cycle();
            if (net_enable_o) sent++;
        end
        checks++;
        if (sent != 0 || rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL mid_stale: sent=%0d rx_valid=%b expected 0 0", sent, rx_valid_o);
        end
        for (int i = 0; i < 12; i++) begin
            tx_valid_i = (i < 6);
            {tx_payload_i, tx_dest_x_i, tx_dest_y_i} = 16'($urandom);
            cycle();
            if (net_enable_o) sent++;
        end
        tx_valid_i = 1'b0;
        checks++;
        if (sent != 4) begin
            errors++; $display("FAIL mid_credit: sent=%0d expected 4", sent);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tx_valid_i   = 1'($urandom_range(0, 1));
            {tx_payload_i, tx_dest_x_i, tx_dest_y_i} = 16'($urandom);
            net_credit_i = ($urandom_range(0, 2) == 0);
            net_enable_i = ($urandom_range(0, 2) == 0);
            net_data_i   = 16'($urandom);
            rx_pop_i     = ($urandom_range(0, 3) != 0);
            cycle();
            checks++;
            if ({tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o} !==
                    {m_tx_q.size() < TX_DEPTH, m_net_en, m_net_cr, m_rx_q.size() > 0, m_ovf} ||
                (m_net_en && net_data_o !== m_net_data) ||
                (m_rx_q.size() > 0 && rx_data_o !== m_rx_q[0])) begin
                errors++;
                $display("FAIL random_cyc%0d: ctl=%b net=%h rx=%h expected ctl=%b net=%h", i,
                         {tx_ready_o, net_enable_o, net_credit_o, rx_valid_o, rx_overflow_o}, net_data_o, rx_data_o,
                         {m_tx_q.size() < TX_DEPTH, m_net_en, m_net_cr, m_rx_q.size() > 0, m_ovf}, m_net_data);
            end
        end
        clear_inputs();
`ifdef NOC_NI_STATS_EN
        checks++;
        if (tx_flits_o !== 16'(m_tx_cnt) || rx_flits_o !== 16'(m_rx_cnt)) begin
            errors++; $display("FAIL stats: tx=%0d rx=%0d expected %0d %0d", tx_flits_o, rx_flits_o, m_tx_cnt, m_rx_cnt);
        end
`endif
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_tx_latency();
        test_credit_stall();
        test_credit_clamp();
        test_credit_coincident();
        test_rx_basic();
        test_rx_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
